bnn_stream_loader: RTL and testbench



---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_stream_deser.sv | 99 +++++++++
 rtl/bnn_stream_loader.sv | 77 +++++++
 tb/tb_bnn_stream_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the BNN stream loader and its deserialisers.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  localparam int DEF_IMG_DIM     = 28;
  localparam int DEF_KERNEL      = 3;
  localparam int DEF_NUM_FILTERS = 8;

  localparam int P_TOT = DEF_IMG_DIM * DEF_IMG_DIM;
  localparam int W_TOT = DEF_NUM_FILTERS * DEF_KERNEL * DEF_KERNEL;

endpackage

// File: rtl/bnn_stream_deser.sv
// One-stream deserialiser: packs LANES bits per beat into a TOTAL-bit image.
// With LOADER_PARITY_EN defined, one extra beat carries the even-parity bit in lane 0.
module bnn_stream_deser #(
  parameter int TOTAL = 784,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             beat,
  input  logic [LANES-1:0] d_in,
  output logic [TOTAL-1:0] data,
  output logic             done,
  output logic             parity_err
);

  localparam int CW = $clog2(TOTAL + 1);
  localparam int IW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [TOTAL-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [IW-1:0]    idx;
  int               base;

`ifdef LOADER_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    idx    = '0;
    base   = int'(cnt_q);
`ifdef LOADER_PARITY_EN
    perr_d = perr_q;
`endif
    if (clear) begin
      data_d = '0;
      cnt_d  = '0;
      done_d = 1'b0;
`ifdef LOADER_PARITY_EN
      perr_d = 1'b0;
`endif
    end else if (beat && !done_q) begin
      if (base < TOTAL) begin
        // Lanes past the end of the image fall off; the counter saturates at TOTAL.
        for (int i = 0; i < LANES; i++) begin
          if (base + i < TOTAL) begin
            idx         = IW'(base + i);
            data_d[idx] = d_in[i];
          end
        end
        if (base + LANES >= TOTAL) begin
          cnt_d = CW'(TOTAL);
`ifndef LOADER_PARITY_EN
          done_d = 1'b1;
`endif
        end else begin
          cnt_d = CW'(base + LANES);
        end
      end
`ifdef LOADER_PARITY_EN
      else begin
        done_d = 1'b1;
        if (d_in[0] != ^data_q) perr_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
`ifdef LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
`ifdef LOADER_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign data = data_q;
  assign done = done_q;
`ifdef LOADER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/bnn_stream_loader.sv
// Loads the pixel image and layer-1 weights from two serial streams behind a start handshake.
// Optional parity beat per stream enabled by defining LOADER_PARITY_EN.
module bnn_stream_loader
  import bnn_pkg::*;
#(
  parameter int IMG_DIM     = DEF_IMG_DIM,
  parameter int KERNEL      = DEF_KERNEL,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int LANES       = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                valid,
  input  logic [LANES-1:0]                    d_in_p,
  input  logic [LANES-1:0]                    d_in_w,
  output logic                                ready,
  output logic [IMG_DIM*IMG_DIM-1:0]          pixels,
  output logic [NUM_FILTERS*KERNEL*KERNEL-1:0] weights,
  output logic                                pix_done,
  output logic                                wgt_done,
  output logic                                load_done,
  output logic                                parity_err
);

  localparam int PIX_BITS = IMG_DIM * IMG_DIM;
  localparam int WGT_BITS = NUM_FILTERS * KERNEL * KERNEL;

  loader_state_e state_q, state_d;
  logic          clear, beat;
  logic          pix_perr, wgt_perr;

  // start always wins: it clears both streams and drops any beat presented with it.
  always_comb begin
    state_d = state_q;
    clear   = start;
    beat    = valid && (state_q == LOAD) && !start;
    ready   = (state_q == LOAD);
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (!start && pix_done && wgt_done) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  bnn_stream_deser #(.TOTAL(PIX_BITS), .LANES(LANES)) u_pix (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .beat       (beat),
    .d_in       (d_in_p),
    .data       (pixels),
    .done       (pix_done),
    .parity_err (pix_perr)
  );

  bnn_stream_deser #(.TOTAL(WGT_BITS), .LANES(LANES)) u_wgt (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .beat       (beat),
    .d_in       (d_in_w),
    .data       (weights),
    .done       (wgt_done),
    .parity_err (wgt_perr)
  );

  assign load_done  = pix_done & wgt_done;
  assign parity_err = pix_perr | wgt_perr;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Directed self-checking bench for bnn_stream_loader (default build and LOADER_PARITY_EN build).
module tb_bnn_stream_loader;
  import bnn_pkg::*;

`ifdef LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, valid;
  logic [0:0]         d_in_p, d_in_w;
  logic               ready, pix_done, wgt_done, load_done, parity_err;
  logic [P_TOT-1:0]   pixels;
  logic [W_TOT-1:0]   weights;

  logic               start4, valid4;
  logic [3:0]         d_in_p4, d_in_w4;
  logic               ready4, pix_done4, wgt_done4, load_done4, parity_err4;
  logic [24:0]        pixels4;
  logic [8:0]         weights4;

  int checks = 0;
  int errors = 0;
  logic [P_TOT-1:0] expPix;
  logic [W_TOT-1:0] expWgt;

  bnn_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .d_in_p(d_in_p), .d_in_w(d_in_w), .ready(ready),
    .pixels(pixels), .weights(weights), .pix_done(pix_done),
    .wgt_done(wgt_done), .load_done(load_done), .parity_err(parity_err)
  );

  bnn_stream_loader #(.IMG_DIM(5), .KERNEL(3), .NUM_FILTERS(1), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .valid(valid4),
    .d_in_p(d_in_p4), .d_in_w(d_in_w4), .ready(ready4),
    .pixels(pixels4), .weights(weights4), .pix_done(pix_done4),
    .wgt_done(wgt_done4), .load_done(load_done4), .parity_err(parity_err4)
  );

  // Drive one cycle of inputs on the main instance, then settle just after the edge.
  task automatic applyStimulus(input logic s, input logic v, input logic p, input logic w);
    start  = s;
    valid  = v;
    d_in_p = p;
    d_in_w = w;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic genPix(input int pat, input int i);
    case (pat)
      0:       return (i % 2) == 1;
      1:       return (i % 3) == 0;
      2:       return 1'b1;
      3:       return i < 5;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic genWgt(input int pat, input int i);
    case (pat)
      0:       return 1'b1;
      1:       return (i % 2) == 1;
      2:       return 1'b0;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Streams nbeats valid beats of a pattern, building the expected images and parity beats.
  task automatic loadAll(input int pat, input int nbeats, input logic badPar);
    logic pp, pw, p, w;
    pp = 1'b0;
    pw = 1'b0;
    expPix = '0;
    expWgt = '0;
    for (int i = 0; i < nbeats; i++) begin
      if (i < P_TOT) begin
        p = genPix(pat, i);
        expPix[i] = p;
        pp ^= p;
      end else if (i == P_TOT) p = pp ^ badPar;
      else p = 1'b0;
      if (i < W_TOT) begin
        w = genWgt(pat, i);
        expWgt[i] = w;
        pw ^= w;
      end else if (i == W_TOT) w = pw;
      else w = genWgt(pat, i);
      applyStimulus(1'b0, 1'b1, p, w);
      if (i == W_TOT + PAR - 2) checkOutput("wgt_done_before_last", wgt_done, 0);
      if (i == W_TOT + PAR - 1) checkOutput("wgt_done_after_last", wgt_done, 1);
      if (i == P_TOT + PAR - 2) begin
        checkOutput("pix_done_before_last", pix_done, 0);
        checkOutput("load_done_before_last", load_done, 0);
      end
      if (i == P_TOT + PAR - 1) begin
        checkOutput("pix_done_after_last", pix_done, 1);
        checkOutput("load_done_after_last", load_done, 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; valid4 = 1'b0; d_in_p4 = '0; d_in_w4 = '0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_pixels", pixels, 0);
    checkOutput("rst_weights", weights, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_flags", {pix_done, wgt_done, load_done, parity_err}, 0);
    checkOutput("rst_ready4", ready4, 0);
    rst = 1'b0;
    applyStimulus(0, 1, 1, 1);
    checkOutput("idle_ignores_valid", pixels, 0);

    $display("[TB] full load, alternating pixels / all-one weights");
    applyStimulus(1, 0, 0, 0);
    checkOutput("load_ready", ready, 1);
    loadAll(0, P_TOT + PAR, 1'b0);
    checkOutput("t1_pixels", pixels, expPix);
    checkOutput("t1_weights", weights, expWgt);
    checkOutput("t1_pix_low_bits", pixels[3:0], 4'b1010);
    checkOutput("t1_parity_err", parity_err, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("done_ready", ready, 0);
    checkOutput("done_load_done", load_done, 1);

    $display("[TB] DONE hold under random beats");
    repeat (50) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkOutput("hold_pixels", pixels, expPix);
    checkOutput("hold_weights", weights, expWgt);
    checkOutput("hold_ready", ready, 0);
    checkOutput("hold_load_done", load_done, 1);

    $display("[TB] restart mid-load");
    applyStimulus(1, 0, 0, 0);
    loadAll(2, 300, 1'b0);
    checkOutput("partial_pixels", pixels, expPix);
    checkOutput("partial_wgt_done", wgt_done, 1);
    applyStimulus(1, 1, 1, 1);
    checkOutput("restart_pixels", pixels, 0);
    checkOutput("restart_weights", weights, 0);
    checkOutput("restart_ready", ready, 1);
    checkOutput("restart_wgt_done", wgt_done, 0);
    loadAll(1, P_TOT + PAR, 1'b0);
    checkOutput("reload_pixels", pixels, expPix);
    checkOutput("reload_weights", weights, expWgt);

    $display("[TB] reset mid-load and in DONE");
    applyStimulus(1, 0, 0, 0);
    loadAll(0, 100, 1'b0);
    rst = 1'b1;
    applyStimulus(0, 1, 1, 1);
    rst = 1'b0;
    checkOutput("midrst_pixels", pixels, 0);
    checkOutput("midrst_weights", weights, 0);
    checkOutput("midrst_flags", {ready, pix_done, wgt_done, load_done}, 0);
    repeat (5) applyStimulus(0, 1, 1, 1);
    checkOutput("postrst_pixels", pixels, 0);
    checkOutput("postrst_ready", ready, 0);
    applyStimulus(1, 0, 0, 0);
    loadAll(0, P_TOT + PAR, 1'b0);
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("donerst_pixels", pixels, 0);
    checkOutput("donerst_weights", weights, 0);
    checkOutput("donerst_flags", {ready, load_done}, 0);

    $display("[TB] four-lane instance, 25 pixels / 9 weights");
    start4 = 1'b1;
    applyStimulus(0, 0, 0, 0);
    start4 = 1'b0; valid4 = 1'b1; d_in_p4 = 4'h5; d_in_w4 = 4'hA;
    for (int b = 0; b < 7 + PAR; b++) begin
      applyStimulus(0, 0, 0, 0);
      if (b == 1 + PAR) checkOutput("l4_wgt_done_early", wgt_done4, 0);
      if (b == 2 + PAR) checkOutput("l4_wgt_done", wgt_done4, 1);
      if (b == 5 + PAR) checkOutput("l4_load_done_early", {pix_done4, load_done4}, 0);
      if (b == 6 + PAR) checkOutput("l4_load_done", {pix_done4, load_done4}, 2'b11);
    end
    valid4 = 1'b0;
    checkOutput("l4_pixels", pixels4, 25'h1555555);
    checkOutput("l4_weights", weights4, 9'h0AA);
    checkOutput("l4_parity_err", parity_err4, 0);

`ifdef LOADER_PARITY_EN
    $display("[TB] parity checking");
    applyStimulus(1, 0, 0, 0);
    loadAll(3, P_TOT + PAR, 1'b0);
    checkOutput("par_good_err", parity_err, 0);
    applyStimulus(1, 0, 0, 0);
    loadAll(3, P_TOT + PAR, 1'b1);
    checkOutput("par_bad_err", parity_err, 1);
    checkOutput("par_bad_load_done", load_done, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("par_cleared", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
